dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Load/store initiator that sits between the execute stage and the byte-addressed data memory; it drives the memory's addr/dataw/word/rw/cs port.
- Accepts one load or store request at a time and computes the effective address (base + imm).
- Checks alignment, drives a single memory access cycle, and for loads sign- or zero-extends the read data.
- Returns a response through a valid/ready handshake.

Parameters:
- AW, 12, memory address width; the memory holds 2^AW bytes.
- XLEN, 64, register and data width.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  LSU can accept a request (high only in IDLE).
- req_store  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV64 funct3: size in [1:0], unsigned-load flag in [2].
- req_base  input  XLEN  base register value.
- req_imm  input  12  signed offset.
- req_wdata  input  XLEN  store data; low bytes are used.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  XLEN  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned or illegal request.
- mem_addr  output  AW  byte address to the memory.
- mem_dataw  output  XLEN  write data to the memory.
- mem_word  output  2  access size: 00 byte, 01 half, 10 word, 11 double.
- mem_rw  output  1  1 = write.
- mem_cs  output  1  memory chip select.
- mem_datar  input  XLEN  combinational read data, little-endian from mem_addr.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - req_ready=1 (it is high in IDLE), resp_valid=0, resp_rdata=0, resp_err=0.
  - mem_cs=0, mem_rw=0, mem_addr=0, mem_dataw=0, mem_word=0.
  - Reset during ACCESS drops mem_cs immediately; no write completes.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, the request is accepted.
  - Latch ea = req_base + sext(req_imm), computed modulo 2^XLEN.
  - Latch size=req_funct3[1:0], uns=req_funct3[2], store flag, and wdata.
  - Illegal if the store flag is set with funct3[2]=1, or on a load with funct3=111.
  - Misaligned if ea[size-1:0] != 0 (a byte access is never misaligned).
  - Illegal or misaligned: go to RESP with resp_err=1 and resp_rdata=0; mem_cs is never asserted.
  - Otherwise: go to ACCESS.
- ACCESS (exactly 1 cycle):
  - Drive mem_cs=1, mem_addr=ea[AW-1:0], mem_word=size, mem_rw=store, mem_dataw=wdata.
  - Store: the memory writes at the closing edge.
  - Load: at the closing edge, capture mem_datar[8*2^size-1:0] and extend it to XLEN (zero-extend if uns, else sign-extend) into resp_rdata.
  - Go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until resp_ready.
  - On resp_ready: return to IDLE. The next request is accepted no earlier than the following cycle.
- Outside ACCESS: mem_cs=0 and mem_rw=0.
- Latency: request accepted at edge N → mem_cs high in cycle N+1 → resp_valid from N+2. Best case is one request every 3 cycles.
- Simultaneous events: req_valid during ACCESS or RESP is ignored because req_ready=0. resp_ready outside RESP has no effect.
- Address: upper ea bits above AW are discarded; the default (no optional feature) wraps into the memory.

Optional Feature:
- Macro: DMEM_LSU_BOUNDS_CHECK_EN.
- Defined: in IDLE, a request is flagged as an error if ea[XLEN-1:AW] != 0 or ea[AW-1:0] + 2^size > 2^AW.
  - It is then handled like a misaligned request: RESP with resp_err=1 and no mem_cs pulse.
- Undefined: there is no range check; mem_addr = ea[AW-1:0].

Test Plan:
- Reset with rst_n=0 mid-ACCESS for a store SD to 0x010 → mem_cs drops immediately. Reading 0x010 afterwards returns the prior contents. All outputs hold their reset values.
- SD: base=0x100, imm=-8, wdata=0x8877665544332211 → cycle N+1 shows mem_cs=1, mem_rw=1, mem_addr=0x0F8, mem_word=11. A later LD from 0x0F8 returns 0x8877665544332211 with resp_err=0.
- After that store, LB from 0x0FF → resp_rdata=0xFFFFFFFFFFFFFF88. LBU → 0x88. LH from 0x0FE → 0xFFFFFFFFFFFF8877. LWU from 0x0FC → 0x0000000088776655.
- LW with ea=0x102 → resp_err=1, resp_rdata=0, mem_cs never high. A store with funct3=100 → resp_err=1 with no memory write.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP → resp_valid and resp_rdata stay stable and req_ready=0 throughout. Return to IDLE the cycle after resp_ready=1.
- Bounds: with DMEM_LSU_BOUNDS_CHECK_EN, LD at ea=0xFFC → resp_err=1. Without the macro, an LD at ea=0x1008 reads mem_addr=0x008 with resp_err=0.

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store initiator between the execute stage and a byte-addressed
// data memory. It accepts one request at a time, forms ea = base + sext(imm),
// checks legality and alignment, runs a single memory cycle, and returns the
// (extended) load data through a valid/ready response handshake.
// Optional feature: define DMEM_LSU_BOUNDS_CHECK_EN to flag any access that
// falls outside the 2^AW-byte memory instead of wrapping into it.
module dmem_lsu #(
    parameter int AW   = 12,
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_base,
    input  logic [11:0]     req_imm,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic [AW-1:0]   mem_addr,
    output logic [XLEN-1:0] mem_dataw,
    output logic [1:0]      mem_word,
    output logic            mem_rw,
    output logic            mem_cs,
    input  logic [XLEN-1:0] mem_datar
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   addr_reg;
    logic [XLEN-1:0] wdata_reg;
    logic [XLEN-1:0] rdata_reg;
    logic [1:0]      size_reg;
    logic            uns_reg;
    logic            store_reg;
    logic            err_reg;

    logic [XLEN-1:0] ea_calc;
    logic            illegal;
    logic            misaligned;
    logic            out_of_range;
    logic            req_err;
    logic [XLEN-1:0] load_ext;

    assign ea_calc = req_base + {{(XLEN-12){req_imm[11]}}, req_imm};

    // Stores have no unsigned variant; funct3=111 is not a defined load.
    assign illegal = (req_store && req_funct3[2]) || (!req_store && (req_funct3 == 3'b111));

    // Natural alignment: the low 'size' address bits must be zero.
    always_comb begin
        misaligned = 1'b0;
        case (req_funct3[1:0])
            2'd1:    misaligned = ea_calc[0];
            2'd2:    misaligned = |ea_calc[1:0];
            2'd3:    misaligned = |ea_calc[2:0];
            default: misaligned = 1'b0;
        endcase
    end

`ifdef DMEM_LSU_BOUNDS_CHECK_EN
    logic [AW:0] end_addr;
    // The last byte touched must stay inside the memory, and no high ea bits may be set.
    assign end_addr     = {1'b0, ea_calc[AW-1:0]} + ((AW+1)'(1) << req_funct3[1:0]);
    assign out_of_range = (|ea_calc[XLEN-1:AW]) || (end_addr > {1'b1, {AW{1'b0}}});
`else
    // High ea bits are simply discarded: accesses wrap into the memory.
    logic unused_ea_hi;
    assign unused_ea_hi = &{1'b0, ea_calc[XLEN-1:AW]};
    assign out_of_range = 1'b0;
`endif

    assign req_err = illegal || misaligned || out_of_range;

    // Pick the accessed bytes of the read data and sign- or zero-extend them.
    always_comb begin
        load_ext = '0;
        case (size_reg)
            2'd0: load_ext = {{(XLEN-8){!uns_reg && mem_datar[7]}},   mem_datar[7:0]};
            2'd1: load_ext = {{(XLEN-16){!uns_reg && mem_datar[15]}}, mem_datar[15:0]};
            2'd2: load_ext = {{(XLEN-32){!uns_reg && mem_datar[31]}}, mem_datar[31:0]};
            default: load_ext = mem_datar;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic: errored requests skip the memory cycle entirely.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = req_err ? RESP : ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request capture on acceptance and load-data capture at the end of ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            size_reg  <= '0;
            uns_reg   <= 1'b0;
            store_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            if (state_reg == IDLE && req_valid) begin
                addr_reg  <= ea_calc[AW-1:0];
                wdata_reg <= req_wdata;
                size_reg  <= req_funct3[1:0];
                uns_reg   <= req_funct3[2];
                store_reg <= req_store;
                err_reg   <= req_err;
                rdata_reg <= '0;
            end
            if (state_reg == ACCESS && !store_reg) begin
                rdata_reg <= load_ext;
            end
        end
    end

    // The memory port is driven only during ACCESS and is idle (all zero) otherwise.
    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_rdata = rdata_reg;
    assign resp_err   = err_reg;
    assign mem_cs     = (state_reg == ACCESS);
    assign mem_rw     = mem_cs && store_reg;
    assign mem_addr   = mem_cs ? addr_reg  : '0;
    assign mem_dataw  = mem_cs ? wdata_reg : '0;
    assign mem_word   = mem_cs ? size_reg  : 2'b00;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed and random load/store traffic against dmem_lsu, with a
// byte-array memory device and a byte-array reference model of memory contents.
module tb_dmem_lsu;
    localparam int AW   = 12;
    localparam int XLEN = 64;
    localparam int MSZ  = 4096;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_store = 1'b0;
    logic [2:0]      req_funct3 = '0;
    logic [XLEN-1:0] req_base = '0;
    logic [11:0]     req_imm = '0;
    logic [XLEN-1:0] req_wdata = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;
    logic [AW-1:0]   mem_addr;
    logic [XLEN-1:0] mem_dataw;
    logic [1:0]      mem_word;
    logic            mem_rw;
    logic            mem_cs;
    logic [XLEN-1:0] mem_datar;

    int checks = 0;
    int errors = 0;

    logic [7:0] dev_mem [MSZ];
    logic [7:0] ref_mem [MSZ];
    bit         filled = 1'b0;

    // Fields seen on the memory port during the most recent ACCESS cycle.
    logic [AW-1:0] last_addr;
    logic [1:0]    last_word;
    logic          last_rw;

    always #5 clk = ~clk;

    dmem_lsu #(.AW(AW), .XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_base(req_base), .req_imm(req_imm),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_dataw(mem_dataw), .mem_word(mem_word),
        .mem_rw(mem_rw), .mem_cs(mem_cs), .mem_datar(mem_datar)
    );

    function automatic logic [7:0] init_byte(int i);
        return 8'((i * 73 + 29) ^ (i >> 5));
    endfunction

    // Memory device: combinational little-endian read, write on the clock edge.
    always_comb begin
        mem_datar = '0;
        for (int i = 0; i < 8; i++) mem_datar[8*i +: 8] = dev_mem[12'(mem_addr + 12'(i))];
    end

    always @(posedge clk) begin
        if (!filled) begin
            for (int i = 0; i < MSZ; i++) dev_mem[i] = init_byte(i);
            filled = 1'b1;
        end else if (mem_cs && mem_rw) begin
            for (int i = 0; i < (1 << mem_word); i++)
                dev_mem[12'(mem_addr + 12'(i))] = mem_dataw[8*i +: 8];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One full request/response transaction, checked against the reference model.
    task automatic xact(input bit st, input logic [2:0] f3, input logic [63:0] base,
                        input logic [11:0] imm, input logic [63:0] wd, input int hold,
                        output logic [63:0] rd, output logic er);
        logic [63:0] ea, v, exp_rd;
        logic [11:0] exp_addr;
        int nb, lat, cs_n;
        bit ill, mis, oob, exp_err;
        logic [63:0] held_rd;
        logic        held_er;

        ea       = base + {{52{imm[11]}}, imm};
        nb       = 1 << f3[1:0];
        exp_addr = ea[11:0];
        ill      = (st && f3[2]) || (!st && f3 == 3'b111);
        mis      = (ea % 64'(nb)) != 0;
        oob      = 1'b0;
`ifdef DMEM_LSU_BOUNDS_CHECK_EN
        oob      = ((ea >> 12) != 0) || (int'(ea % 64'(MSZ)) + nb > MSZ);
`endif
        exp_err  = ill || mis || oob;
        exp_rd   = '0;
        if (!exp_err) begin
            if (st) begin
                for (int i = 0; i < nb; i++) ref_mem[(int'(exp_addr) + i) % MSZ] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < nb; i++)
                    v = v | (64'(ref_mem[(int'(exp_addr) + i) % MSZ]) << (8 * i));
                if (!f3[2] && nb < 8 && v[8*nb-1]) v = v | ~((64'd1 << (8 * nb)) - 1);
                exp_rd = v;
            end
        end

        @(negedge clk);
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1; req_store = st; req_funct3 = f3;
        req_base = base; req_imm = imm; req_wdata = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;

        lat = 0; cs_n = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_cs) begin
                cs_n++;
                last_addr = mem_addr; last_word = mem_word; last_rw = mem_rw;
                chk("acc_addr", 64'(mem_addr), 64'(exp_addr));
                chk("acc_word", 64'(mem_word), 64'(f3[1:0]));
                chk("acc_rw", 64'(mem_rw), 64'(st));
                chk("acc_dataw", mem_dataw, wd);
                chk("acc_req_ready", 64'(req_ready), 64'd0);
            end
            if (resp_valid) begin
                lat = k;
                break;
            end
        end
        chk("latency", 64'(lat), exp_err ? 64'd1 : 64'd2);
        chk("cs_pulses", 64'(cs_n), exp_err ? 64'd0 : 64'd1);
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_err", 64'(resp_err), 64'(exp_err));
        rd = resp_rdata; er = resp_err;
        held_rd = resp_rdata; held_er = resp_err;

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_ready", 64'(req_ready), 64'd0);
            chk("hold_rdata", resp_rdata, held_rd);
            chk("hold_err", 64'(resp_err), 64'(held_er));
            chk("hold_cs", 64'(mem_cs), 64'd0);
        end

        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("back_idle_valid", 64'(resp_valid), 64'd0);
        chk("back_idle_ready", 64'(req_ready), 64'd1);
        $display("xact st=%0d f3=%0d ea=%h err=%0d rdata=%h", st, f3, ea, er, rd);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_resp_rdata"}, resp_rdata, 64'd0);
        chk({tag, "_resp_err"}, 64'(resp_err), 64'd0);
        chk({tag, "_mem_cs"}, 64'(mem_cs), 64'd0);
        chk({tag, "_mem_rw"}, 64'(mem_rw), 64'd0);
        chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_mem_dataw"}, mem_dataw, 64'd0);
        chk({tag, "_mem_word"}, 64'(mem_word), 64'd0);
    endtask

    initial begin
        logic [63:0] rd;
        logic        er;
        bit          st;
        logic [2:0]  f3;
        logic [63:0] base;
        logic [11:0] imm;

        for (int i = 0; i < MSZ; i++) ref_mem[i] = init_byte(i);

        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;

        // Reset in the middle of a store's ACCESS cycle: no write may land.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b011;
        req_base = 64'h10; req_imm = 12'h000; req_wdata = 64'hDEADBEEFCAFEF00D;
        @(posedge clk);
        #1 req_valid = 1'b0;
        chk("rst_pre_cs", 64'(mem_cs), 64'd1);
        rst_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset during ACCESS of SD 0x010");
        xact(1'b0, 3'b011, 64'h10, 12'h000, 64'h0, 0, rd, er);

        // Directed store/load sequence.
        xact(1'b1, 3'b011, 64'h100, 12'hFF8, 64'h8877665544332211, 0, rd, er);
        chk("sd_addr", 64'(last_addr), 64'h0F8);
        chk("sd_word", 64'(last_word), 64'd3);
        chk("sd_rw", 64'(last_rw), 64'd1);
        xact(1'b0, 3'b011, 64'h0F8, 12'h000, 64'h0, 0, rd, er);
        chk("ld_val", rd, 64'h8877665544332211);
        chk("ld_err", 64'(er), 64'd0);
        xact(1'b0, 3'b000, 64'h0FF, 12'h000, 64'h0, 0, rd, er);
        chk("lb_val", rd, 64'hFFFFFFFFFFFFFF88);
        xact(1'b0, 3'b100, 64'h0FF, 12'h000, 64'h0, 0, rd, er);
        chk("lbu_val", rd, 64'h88);
        xact(1'b0, 3'b001, 64'h0FE, 12'h000, 64'h0, 0, rd, er);
        chk("lh_val", rd, 64'hFFFFFFFFFFFF8877);
        xact(1'b0, 3'b110, 64'h0FC, 12'h000, 64'h0, 0, rd, er);
        chk("lwu_val", rd, 64'h0000000088776655);
        xact(1'b0, 3'b010, 64'h102, 12'h000, 64'h0, 0, rd, er);
        chk("lw_mis_err", 64'(er), 64'd1);
        chk("lw_mis_rd", rd, 64'd0);
        xact(1'b1, 3'b100, 64'h200, 12'h000, 64'hFFFFFFFFFFFFFFFF, 0, rd, er);
        chk("st_ill_err", 64'(er), 64'd1);
        xact(1'b0, 3'b011, 64'h200, 12'h000, 64'h0, 0, rd, er);
        xact(1'b0, 3'b111, 64'h200, 12'h000, 64'h0, 0, rd, er);
        chk("ld111_err", 64'(er), 64'd1);

        // Backpressure: five cycles without resp_ready.
        xact(1'b0, 3'b011, 64'h0F8, 12'h000, 64'h0, 5, rd, er);

        // Range: top-of-memory and wrapped addresses.
        xact(1'b0, 3'b011, 64'hFF8, 12'h004, 64'h0, 0, rd, er);
        chk("ld_ffc_err", 64'(er), 64'd1);
        xact(1'b0, 3'b011, 64'h1000, 12'h008, 64'h0, 0, rd, er);
`ifdef DMEM_LSU_BOUNDS_CHECK_EN
        chk("ld_1008_err", 64'(er), 64'd1);
`else
        chk("ld_1008_err", 64'(er), 64'd0);
        chk("ld_1008_addr", 64'(last_addr), 64'h008);
`endif

        // Random traffic.
        for (int n = 0; n < 200; n++) begin
            st   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) base = {$urandom, $urandom};
            else                           base = 64'($urandom_range(0, MSZ - 1));
            imm  = 12'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                base = base & ~64'h7;
                imm  = imm & ~12'h7;
            end
            if (st && $urandom_range(0, 3) != 0) f3[2] = 1'b0;
            xact(st, f3, base, imm, {$urandom, $urandom}, $urandom_range(0, 3), rd, er);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
